// File: rtl/sad_min_tracker.sv
//------------------------------------------------------------------------------
// sad_min_tracker
//
// Final sequential stage of the motion-estimation SAD reduction. Streams beats
// of LANES (SAD, index) pairs, keeps the global minimum over a whole search,
// then turns the winning linear index into (row, col) by repeated subtraction
// of SEARCH_COLS. The result is offered on a valid/ready handshake.
//
// Ports:
//   i_clk         clock, rising edge
//   i_rst_n       asynchronous active-low reset
//   i_start       begin a new search (honoured in IDLE only)
//   i_in_valid    input beat valid
//   o_in_ready    tracker accepts a beat (COLLECT only)
//   i_in_sad      LANES packed SADs, lane 0 in the LSBs
//   i_in_index    LANES packed candidate indices, lane 0 in the LSBs
//   i_in_mask     per-lane valid, 0 = lane ignored
//   i_in_last     final beat of the search
//   o_out_valid   result valid
//   i_out_ready   consumer accepts result
//   o_best_sad    minimum SAD
//   o_best_index  index of the minimum
//   o_best_row    best_index / SEARCH_COLS
//   o_best_col    best_index % SEARCH_COLS
//   o_out_err     no valid candidate seen, or index outside the window
//   o_busy        tracker not idle
//------------------------------------------------------------------------------
module sad_min_tracker #(
  parameter int LANES       = 7,
  parameter int SAD_W       = 32,
  parameter int IDX_W       = 32,
  parameter int SEARCH_COLS = 49,
  parameter int SEARCH_ROWS = 49
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_start,
  input  logic                   i_in_valid,
  output logic                   o_in_ready,
  input  logic [LANES*SAD_W-1:0] i_in_sad,
  input  logic [LANES*IDX_W-1:0] i_in_index,
  input  logic [LANES-1:0]       i_in_mask,
  input  logic                   i_in_last,
  output logic                   o_out_valid,
  input  logic                   i_out_ready,
  output logic [SAD_W-1:0]       o_best_sad,
  output logic [IDX_W-1:0]       o_best_index,
  output logic [IDX_W-1:0]       o_best_row,
  output logic [IDX_W-1:0]       o_best_col,
  output logic                   o_out_err,
  output logic                   o_busy
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_CONVERT = 2'd2;
  localparam logic [1:0] S_OUTPUT  = 2'd3;

  localparam logic [IDX_W-1:0] L_COLS  = IDX_W'(SEARCH_COLS);
  localparam logic [IDX_W-1:0] L_TOTAL = IDX_W'(SEARCH_ROWS * SEARCH_COLS);

  logic [1:0]       r_state;
  logic [SAD_W-1:0] r_best_sad;
  logic [IDX_W-1:0] r_best_index;
  logic [IDX_W-1:0] r_best_row;
  logic [IDX_W-1:0] r_best_col;
  logic             r_found;
  logic             r_err;
  logic [IDX_W-1:0] r_rem;
  logic [IDX_W-1:0] r_row;

  logic [SAD_W-1:0] w_lane_sad [LANES];
  logic [IDX_W-1:0] w_lane_idx [LANES];
  logic [SAD_W-1:0] w_scan_sad;
  logic [IDX_W-1:0] w_scan_idx;
  logic             w_accept;
  logic             w_bad;

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      assign w_lane_sad[gi] = i_in_sad[gi*SAD_W +: SAD_W];
      assign w_lane_idx[gi] = i_in_index[gi*IDX_W +: IDX_W];
    end
  endgenerate

  // Lanes are folded in ascending order with a strict compare, so on equal
  // SADs the running best (earlier beat) or the lower lane is retained.
  always_comb begin
    w_scan_sad = r_best_sad;
    w_scan_idx = r_best_index;
    for (int li = 0; li < LANES; li++) begin
      if (i_in_mask[li] && (w_lane_sad[li] < w_scan_sad)) begin
        w_scan_sad = w_lane_sad[li];
        w_scan_idx = w_lane_idx[li];
      end
    end
  end

  assign w_accept = i_in_valid && (r_state == S_COLLECT);

  // best_index and found are frozen during CONVERT, so evaluating this every
  // CONVERT cycle is equivalent to checking it only on the first one; a bad
  // index therefore never reaches the subtraction loop and row cannot wrap.
  assign w_bad = !r_found || (r_best_index >= L_TOTAL);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_best_sad   <= '1;
      r_best_index <= '0;
      r_best_row   <= '0;
      r_best_col   <= '0;
      r_found      <= 1'b0;
      r_err        <= 1'b0;
      r_rem        <= '0;
      r_row        <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_state      <= S_COLLECT;
            r_best_sad   <= '1;
            r_best_index <= '0;
            r_found      <= 1'b0;
            r_err        <= 1'b0;
          end
        end
        S_COLLECT: begin
          if (w_accept) begin
            r_best_sad   <= w_scan_sad;
            r_best_index <= w_scan_idx;
            if (|i_in_mask) begin
              r_found <= 1'b1;
            end
            if (i_in_last) begin
              r_state <= S_CONVERT;
              r_rem   <= w_scan_idx;
              r_row   <= '0;
            end
          end
        end
        S_CONVERT: begin
          if (w_bad) begin
            r_err      <= 1'b1;
            r_best_row <= '0;
            r_best_col <= '0;
            r_state    <= S_OUTPUT;
          end else if (r_rem >= L_COLS) begin
            r_rem <= r_rem - L_COLS;
            r_row <= r_row + IDX_W'(1);
          end else begin
            r_best_col <= r_rem;
            r_best_row <= r_row;
            r_state    <= S_OUTPUT;
          end
        end
        S_OUTPUT: begin
          if (i_out_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_in_ready   = (r_state == S_COLLECT);
  assign o_out_valid  = (r_state == S_OUTPUT);
  assign o_busy       = (r_state != S_IDLE);
  assign o_best_sad   = r_best_sad;
  assign o_best_index = r_best_index;
  assign o_best_row   = r_best_row;
  assign o_best_col   = r_best_col;
  assign o_out_err    = r_err;

endmodule

// File: tb/tb_sad_min_tracker.sv
module tb_sad_min_tracker;

  localparam int LANES = 7;
  localparam int SAD_W = 32;
  localparam int IDX_W = 32;
  localparam int COLS  = 49;
  localparam int ROWS  = 49;

  logic                   i_clk;
  logic                   i_rst_n;
  logic                   i_start;
  logic                   i_in_valid;
  logic                   o_in_ready;
  logic [LANES*SAD_W-1:0] i_in_sad;
  logic [LANES*IDX_W-1:0] i_in_index;
  logic [LANES-1:0]       i_in_mask;
  logic                   i_in_last;
  logic                   o_out_valid;
  logic                   i_out_ready;
  logic [SAD_W-1:0]       o_best_sad;
  logic [IDX_W-1:0]       o_best_index;
  logic [IDX_W-1:0]       o_best_row;
  logic [IDX_W-1:0]       o_best_col;
  logic                   o_out_err;
  logic                   o_busy;

  sad_min_tracker #(
    .LANES(LANES), .SAD_W(SAD_W), .IDX_W(IDX_W),
    .SEARCH_COLS(COLS), .SEARCH_ROWS(ROWS)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start),
    .i_in_valid(i_in_valid), .o_in_ready(o_in_ready),
    .i_in_sad(i_in_sad), .i_in_index(i_in_index), .i_in_mask(i_in_mask),
    .i_in_last(i_in_last), .o_out_valid(o_out_valid), .i_out_ready(i_out_ready),
    .o_best_sad(o_best_sad), .o_best_index(o_best_index),
    .o_best_row(o_best_row), .o_best_col(o_best_col),
    .o_out_err(o_out_err), .o_busy(o_busy)
  );

  typedef struct {
    logic [LANES*SAD_W-1:0] sad;
    logic [LANES*IDX_W-1:0] idx;
    logic [LANES-1:0]       mask;
  } beat_t;

  typedef struct {
    logic [SAD_W-1:0] sad;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] row;
    logic [IDX_W-1:0] col;
    logic             err;
    int               lat;
    int               t_valid;
    int               stall;
    int               id;
  } exp_t;

  beat_t beats[$];
  exp_t  exp_q[$];
  int    n_checks = 0;
  int    n_err    = 0;
  int    cyc      = 0;
  int    search_id = 0;

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic logic [LANES*32-1:0] pack7(input int a0, input int a1, input int a2,
                                                 input int a3, input int a4, input int a5,
                                                 input int a6);
    return {a6[31:0], a5[31:0], a4[31:0], a3[31:0], a2[31:0], a1[31:0], a0[31:0]};
  endfunction

  task automatic add_beat(input logic [LANES*SAD_W-1:0] s, input logic [LANES*IDX_W-1:0] ix,
                          input logic [LANES-1:0] m);
    beat_t b;
    b.sad = s; b.idx = ix; b.mask = m;
    beats.push_back(b);
  endtask

  // Reference: minimum over the whole search in arrival order with first
  // occurrence winning, then row/col by integer division.
  function automatic exp_t model();
    exp_t e;
    bit   found;
    logic [SAD_W-1:0] s;
    found = 0;
    e.sad = '1;
    e.idx = '0;
    foreach (beats[b]) begin
      for (int l = 0; l < LANES; l++) begin
        if (beats[b].mask[l]) begin
          found = 1;
          s = beats[b].sad[l*SAD_W +: SAD_W];
          if (s < e.sad) begin
            e.sad = s;
            e.idx = beats[b].idx[l*IDX_W +: IDX_W];
          end
        end
      end
    end
    e.err = !found || (e.idx >= IDX_W'(ROWS * COLS));
    e.row = e.err ? '0 : e.idx / IDX_W'(COLS);
    e.col = e.err ? '0 : e.idx % IDX_W'(COLS);
    e.lat = e.err ? 2 : int'(e.row) + 2;
    e.t_valid = 0;
    e.stall = 0;
    e.id = 0;
    return e;
  endfunction

  task automatic drive_beat(input beat_t b, input bit last);
    i_in_sad   = b.sad;
    i_in_index = b.idx;
    i_in_mask  = b.mask;
    i_in_last  = last;
    i_in_valid = 1'b1;
  endtask

  // Issues the queued beats as one search. Called at a negedge with the DUT idle.
  task automatic run_search(input int stall, input bit early, input bit start_mid,
                            input bit start_out, input bit rand_gaps);
    exp_t e;
    int   t_last;
    int   n;
    e = model();
    e.stall = stall;
    e.id = search_id;
    t_last = 0;
    if (early) begin
      drive_beat(beats[0], beats.size() == 1);
      for (int k = 0; k < 3; k++) begin
        check($sformatf("search %0d in_ready while idle", search_id), o_in_ready, 0);
        @(negedge i_clk);
      end
    end
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    check($sformatf("search %0d busy after start", search_id), o_busy, 1);
    for (int b = 0; b < beats.size(); b++) begin
      if (b > 0 && (start_mid || (rand_gaps && $urandom_range(0, 2) == 0))) begin
        i_in_valid = 1'b0;
        i_start = start_mid;
        @(negedge i_clk);
        i_start = 1'b0;
      end
      drive_beat(beats[b], b == beats.size() - 1);
      check($sformatf("search %0d in_ready in collect", search_id), o_in_ready, 1);
      t_last = cyc;
      @(negedge i_clk);
    end
    i_in_valid = 1'b0;
    i_in_last  = 1'b0;
    e.t_valid = t_last + e.lat;
    exp_q.push_back(e);
    if (start_out) begin
      n = 0;
      while (!o_out_valid && n < 100) begin
        @(negedge i_clk);
        n++;
      end
      i_start = 1'b1;
      @(negedge i_clk);
      i_start = 1'b0;
    end
    beats.delete();
    search_id++;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge i_clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      n_err++;
      $display("FAIL drain timeout: %0d results outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(negedge i_clk);
    check("busy after result taken", o_busy, 0);
    check("out_valid after result taken", o_out_valid, 0);
  endtask

  // Monitor: compares every presented result against the scoreboard head,
  // applies the per-result stall, and confirms out_valid drops after handshake.
  initial begin : monitor
    exp_t e;
    int   stall_left;
    bit   prev_valid;
    bit   pending_drop;
    stall_left = 0;
    prev_valid = 0;
    pending_drop = 0;
    i_out_ready = 1'b0;
    forever begin
      @(negedge i_clk);
      if (pending_drop) begin
        check("out_valid drop after handshake", o_out_valid, 0);
        pending_drop = 0;
      end
      if (o_out_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL unexpected out_valid: got 1 expected 0 (no result pending)");
          i_out_ready = 1'b1;
        end else begin
          e = exp_q[0];
          if (!prev_valid) begin
            check($sformatf("search %0d out_valid cycle", e.id), cyc, e.t_valid);
            stall_left = e.stall;
          end
          check($sformatf("search %0d best_sad", e.id), o_best_sad, e.sad);
          check($sformatf("search %0d best_index", e.id), o_best_index, e.idx);
          check($sformatf("search %0d best_row", e.id), o_best_row, e.row);
          check($sformatf("search %0d best_col", e.id), o_best_col, e.col);
          check($sformatf("search %0d out_err", e.id), o_out_err, e.err);
          if (stall_left > 0) begin
            stall_left--;
            i_out_ready = 1'b0;
          end else begin
            i_out_ready = 1'b1;
            void'(exp_q.pop_front());
            pending_drop = 1;
          end
        end
      end else begin
        i_out_ready = 1'b0;
      end
      prev_valid = o_out_valid;
    end
  end

  initial begin : stimulus
    logic [LANES*SAD_W-1:0] s;
    logic [LANES*IDX_W-1:0] ix;
    int nb;
    i_rst_n = 1'b0;
    i_start = 1'b0;
    i_in_valid = 1'b0;
    i_in_sad = '0;
    i_in_index = '0;
    i_in_mask = '0;
    i_in_last = 1'b0;
    repeat (3) @(negedge i_clk);
    check("reset in_ready", o_in_ready, 0);
    check("reset out_valid", o_out_valid, 0);
    check("reset busy", o_busy, 0);
    check("reset out_err", o_out_err, 0);
    check("reset best_sad", o_best_sad, 64'hFFFF_FFFF);
    check("reset best_index", o_best_index, 0);
    check("reset best_row", o_best_row, 0);
    check("reset best_col", o_best_col, 0);
    i_rst_n = 1'b1;
    @(negedge i_clk);

    // Single beat with a tie between lanes 1 and 3.
    add_beat(pack7(90, 40, 70, 40, 95, 99, 80), pack7(100, 101, 102, 103, 104, 105, 106), 7'h7F);
    run_search(0, 1, 0, 0, 0);
    wait_drain();

    // Three beats, last beat wins at the window corner; start pulsed mid-collect.
    add_beat(pack7(50, 60, 70, 80, 90, 55, 65), pack7(10, 11, 12, 13, 14, 15, 16), 7'h7F);
    add_beat(pack7(70, 50, 90, 80, 60, 55, 75), pack7(1999, 2000, 2001, 2002, 2003, 2004, 2005), 7'h7F);
    add_beat(pack7(80, 90, 49, 70, 60, 55, 75), pack7(2398, 2399, 2400, 2396, 2397, 2395, 2394), 7'h7F);
    run_search(0, 0, 1, 0, 0);
    wait_drain();

    // Same but last beat no better: earliest equal minimum retained.
    add_beat(pack7(50, 60, 70, 80, 90, 55, 65), pack7(10, 11, 12, 13, 14, 15, 16), 7'h7F);
    add_beat(pack7(70, 50, 90, 80, 60, 55, 75), pack7(1999, 2000, 2001, 2002, 2003, 2004, 2005), 7'h7F);
    add_beat(pack7(80, 90, 60, 70, 61, 65, 75), pack7(2398, 2399, 2400, 2396, 2397, 2395, 2394), 7'h7F);
    run_search(0, 0, 0, 0, 0);
    wait_drain();

    // Masked-off lane 0 carries the smallest SAD.
    add_beat(pack7(0, 9, 7, 5, 8, 6, 12), pack7(200, 201, 202, 203, 204, 205, 206), 7'h7E);
    run_search(0, 0, 0, 0, 0);
    wait_drain();

    // Nothing valid at all.
    add_beat(pack7(1, 2, 3, 4, 5, 6, 7), pack7(1, 2, 3, 4, 5, 6, 7), 7'h00);
    run_search(0, 0, 0, 0, 0);
    wait_drain();

    // Index just outside, then exactly at the last window position.
    add_beat(pack7(10, 10, 3, 10, 10, 10, 10), pack7(5, 6, 2401, 7, 8, 9, 4), 7'h7F);
    run_search(0, 0, 0, 0, 0);
    wait_drain();
    add_beat(pack7(10, 10, 3, 10, 10, 10, 10), pack7(5, 6, 2400, 7, 8, 9, 4), 7'h7F);
    run_search(0, 0, 0, 0, 0);
    wait_drain();

    // Consumer stalls 5 cycles; start pulsed while the result is held.
    add_beat(pack7(30, 20, 25, 21, 40, 22, 23), pack7(300, 500, 301, 302, 303, 304, 305), 7'h7F);
    run_search(5, 0, 0, 1, 0);
    wait_drain();

    // Reset in the middle of a long conversion discards the partial result.
    add_beat(pack7(1, 2, 3, 4, 5, 6, 7), pack7(2400, 2, 3, 4, 5, 6, 7), 7'h7F);
    run_search(0, 0, 0, 0, 0);
    repeat (10) @(negedge i_clk);
    check("pre-reset busy in convert", o_busy, 1);
    i_rst_n = 1'b0;
    #1;
    check("async reset out_valid", o_out_valid, 0);
    check("async reset busy", o_busy, 0);
    check("async reset best_sad", o_best_sad, 64'hFFFF_FFFF);
    check("async reset best_index", o_best_index, 0);
    check("async reset out_err", o_out_err, 0);
    exp_q.delete();
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    check("post-reset busy", o_busy, 0);

    // Randomized searches with small SAD range to provoke ties.
    for (int r = 0; r < 25; r++) begin
      nb = $urandom_range(1, 4);
      for (int b = 0; b < nb; b++) begin
        for (int l = 0; l < LANES; l++) begin
          s[l*SAD_W +: SAD_W]  = SAD_W'($urandom_range(0, 31));
          ix[l*IDX_W +: IDX_W] = IDX_W'($urandom_range(0, 2450));
        end
        add_beat(s, ix, ($urandom_range(0, 5) == 0) ? 7'h00 : LANES'($urandom));
      end
      run_search($urandom_range(0, 3), $urandom_range(0, 1) == 1, 0, 0, 1);
      wait_drain();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
